// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_store_unit_pkg                                        |
// | Description : Shared size encodings, FSM state encoding and byte/lane    |
// |               mask helpers for the load/store unit.                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package load_store_unit_pkg;

  // Access size encodings; 2'b11 falls into the word branch wherever decoded.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC1 = 2'd1,
    ST_ACC2 = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Number of bytes moved by an access of the given size (1, 2 or 4).
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_B:  n = 3'd1;
      SIZE_H:  n = 3'd2;
      SIZE_W:  n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // One strobe bit per byte lane, the low nbytes lanes set.
  function automatic logic [3:0] lane_mask(input logic [2:0] nbytes);
    logic [3:0] m;
    case (nbytes)
      3'd0:    m = 4'b0000;
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Bit mask covering the low nbytes bytes of a word.
  function automatic logic [31:0] byte_mask(input logic [2:0] nbytes);
    logic [3:0]  lm;
    logic [31:0] m;
    lm = lane_mask(nbytes);
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{lm[i]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lsu_align                                                  |
// | Description : Combinational alignment datapath. For the current memory   |
// |               cycle (first or second word) produces lane strobes, the    |
// |               shifted store data and the merged load capture buffer, and |
// |               sign/zero-extends the merged load result.                  |
// | Ports       : i_size/i_unsigned/i_off - latched access shape             |
// |               i_second    - 1 while accessing the second word            |
// |               i_wdata     - right-justified store data                   |
// |               i_mem_rdata - memory read data (already shifted by offset) |
// |               i_buf       - capture buffer holding first-word bytes      |
// |               o_split     - access spans two words                       |
// |               o_wstrb     - lane strobes for this memory cycle           |
// |               o_wdata     - lane-aligned store data for this cycle       |
// |               o_buf_next  - capture buffer after merging this cycle      |
// |               o_ext       - o_buf_next extended to 32 bits               |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic        i_second,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic [31:0] i_buf,
  output logic        o_split,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_buf_next,
  output logic [31:0] o_ext
);

  logic [2:0]  w_n;      // total bytes
  logic [2:0]  w_first;  // bytes reachable in the first word: 4 - off
  logic [2:0]  w_n1;     // bytes moved in the first cycle
  logic [2:0]  w_n2;     // bytes left for the second cycle
  logic [5:0]  w_sh;     // bit distance between first-word and second-word bytes
  logic [31:0] w_buf;

  assign w_n     = size_bytes(i_size);
  assign w_first = 3'd4 - {1'b0, i_off};
  assign w_n1    = (w_n < w_first) ? w_n : w_first;
  assign w_n2    = w_n - w_n1;
  assign w_sh    = {w_first, 3'b000};
  assign o_split = ({1'b0, i_off} + w_n) > 3'd4;

  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = i_wdata;
    w_buf   = '0;
    if (i_second) begin
      // Bytes already written/read in the first word are dropped from the
      // store data and stacked above the first-word bytes for loads.
      o_wstrb = lane_mask(w_n2);
      o_wdata = i_wdata >> w_sh;
      w_buf   = i_buf | ((i_mem_rdata << w_sh) & byte_mask(w_n));
    end else begin
      o_wstrb = lane_mask(w_n1);
      o_wdata = i_wdata;
      w_buf   = i_mem_rdata & byte_mask(w_n1);
    end
  end

  always_comb begin
    o_ext = w_buf;
    case (i_size)
      SIZE_B:  o_ext = i_unsigned ? {24'h0, w_buf[7:0]}  : {{24{w_buf[7]}}, w_buf[7:0]};
      SIZE_H:  o_ext = i_unsigned ? {16'h0, w_buf[15:0]} : {{16{w_buf[15]}}, w_buf[15:0]};
      default: o_ext = w_buf;
    endcase
  end

  assign o_buf_next = w_buf;

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_store_unit                                            |
// | Description : Byte/half/word load-store unit in front of a word memory.  |
// |               Misaligned accesses that cross a word boundary are split   |
// |               into two memory cycles; one response pulse per access.     |
// | Ports       : clk, rst            - clock, synchronous active-high reset |
// |               req_*               - core request (valid/ready handshake) |
// |               resp_*              - completion pulse, load data, split   |
// |               mem_*               - word memory port, byte-lane strobes  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_split,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wenable,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  r_state;
  lsu_state_e  w_state_next;

  logic [31:0] r_addr;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_rdata;
  logic        r_split;

  logic        w_accept;
  logic        w_capture;
  logic        w_finish;
  logic [3:0]  w_wen;
  logic        w_second;
  logic        w_split;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata_al;
  logic [31:0] w_buf_next;
  logic [31:0] w_ext;

  assign w_second = (r_state == ST_ACC2);

  lsu_align u_align (
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .i_off       (r_addr[1:0]),
    .i_second    (w_second),
    .i_wdata     (r_wdata),
    .i_mem_rdata (mem_rdata),
    .i_buf       (r_buf),
    .o_split     (w_split),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata_al),
    .o_buf_next  (w_buf_next),
    .o_ext       (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_finish     = 1'b0;
    w_wen        = 4'b0000;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_ACC1;
        end
      end
      ST_ACC1: begin
        w_capture = ~r_write;
        w_wen     = r_write ? w_wstrb : 4'b0000;
        if (w_split) begin
          w_state_next = ST_ACC2;
        end else begin
          w_state_next = ST_DONE;
          w_finish     = 1'b1;
        end
      end
      ST_ACC2: begin
        w_capture    = ~r_write;
        w_wen        = r_write ? w_wstrb : 4'b0000;
        w_state_next = ST_DONE;
        w_finish     = 1'b1;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_size     <= SIZE_B;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_rdata    <= '0;
      r_split    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= req_addr;
        r_write    <= req_write;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata;
      end
      if (w_capture) begin
        r_buf <= w_buf_next;
      end
      // The response is registered as the last memory cycle retires so it
      // is stable for the whole DONE cycle and held afterwards.
      if (w_finish) begin
        r_rdata <= r_write ? 32'h0 : w_ext;
        r_split <= w_second;
      end
    end
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign resp_valid  = (r_state == ST_DONE);
  assign resp_rdata  = r_rdata;
  assign resp_split  = r_split;
  // Second word address wraps naturally through the 30-bit word index.
  assign mem_addr    = w_second ? {r_addr[31:2] + 30'd1, 2'b00} : r_addr;
  assign mem_wdata   = w_wdata_al;
  // Gate strobes with reset so no write can commit on a reset edge.
  assign mem_wenable = rst ? 4'b0000 : w_wen;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_load_store_unit                                         |
// | Description : Self-checking bench for load_store_unit with a byte-level  |
// |               memory and a byte-array reference model.                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_split;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wenable;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  // Environment memory (aliased on address bits [9:0]) and reference copy.
  logic [7:0] mem     [0:1023];
  logic [7:0] ref_mem [0:1023];

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_split   (resp_split),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wenable  (mem_wenable),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read shifted right by the byte offset, lane k of
  // a write lands at mem_addr + k.
  always_comb begin
    mem_rdata = '0;
    for (int b = 0; b < 4; b++) begin
      if (int'(mem_addr[1:0]) + b < 4) begin
        mem_rdata[8*b +: 8] = mem[mem_addr[9:0] + 10'(b)];
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_wenable[k]) begin
        mem[mem_addr[9:0] + 10'(k)] <= mem_wdata[8*k +: 8];
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    for (int i = 0; i < nbytes(s); i++) begin
      ref_mem[10'(a + 32'(i))] = d[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] v;
    int n;
    n = nbytes(s);
    v = '0;
    for (int i = 0; i < n; i++) begin
      v[8*i +: 8] = ref_mem[10'(a + 32'(i))];
    end
    if (!u && n < 4 && v[8*n-1]) begin
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  function automatic logic ref_split(input logic [31:0] a, input logic [1:0] s);
    return (int'(a[1:0]) + nbytes(s)) > 4;
  endfunction

  // ---------------- drivers ----------------
  // Present a request at posedge+1, wait for acceptance, return at posedge+1
  // of the first cycle after the accept edge with req_* scrambled.
  task automatic start_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d, output bit ok);
    int g;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    g = 0;
    while (req_ready !== 1'b1 && g < 20) begin
      @(posedge clk); #1; g++;
    end
    ok = (g < 20);
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // Full access; lat is the cycle of resp_valid relative to the accept cycle,
  // or -1 / >= 10 when the handshake never completes.
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic sp, output int lat);
    bit ok;
    start_req(w, sz, u, a, d, ok);
    rd = 'x; sp = 'x;
    if (!ok) begin
      lat = -1;
      return;
    end
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    rd = resp_rdata;
    sp = resp_split;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_wenable !== 4'b0000) begin errors++; $display("FAIL reset_wen got=%b exp=0000", mem_wenable); end
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    checks++; if (resp_split !== 1'b0) begin errors++; $display("FAIL reset_split got=%b exp=0", resp_split); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic sp; int lat;
    access(1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, rd, sp, lat);
    ref_store(32'h100, 2'b10, 32'h11223344);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata got=%h exp=0", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, sp, lat);
    checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL lw_rdata got=%h exp=11223344", rd); end
    checks++; if (sp !== 1'b0) begin errors++; $display("FAIL lw_split got=%b exp=0", sp); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL lw_after got=%b%b exp=01", resp_valid, req_ready); end
  endtask

  task automatic test_byte_ext;
    logic [31:0] rd; logic sp; int lat;
    access(1'b1, 2'b10, 1'b0, 32'h100, 32'h80FF0000, rd, sp, lat);
    ref_store(32'h100, 2'b10, 32'h80FF0000);
    access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, rd, sp, lat);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got=%h exp=ffffff80", rd); end
    access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, rd, sp, lat);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_rdata got=%h exp=00000080", rd); end
    access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, rd, sp, lat);
    checks++; if (rd !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_rdata got=%h exp=ffff80ff", rd); end
  endtask

  task automatic test_split;
    logic [31:0] rd; logic sp; int lat; bit ok;
    start_req(1'b1, 2'b10, 1'b0, 32'h102, 32'hAABBCCDD, ok);
    checks++; if (!ok) begin errors++; $display("FAIL split_accept got=timeout exp=accept"); end
    checks++; if (mem_addr !== 32'h102 || mem_wenable !== 4'b0011) begin errors++; $display("FAIL split_acc1 got=%h/%b exp=00000102/0011", mem_addr, mem_wenable); end
    @(posedge clk); #1;
    checks++; if (mem_addr !== 32'h104 || mem_wenable !== 4'b0011 || mem_wdata[15:0] !== 16'hAABB) begin
      errors++; $display("FAIL split_acc2 got=%h/%b/%h exp=00000104/0011/aabb", mem_addr, mem_wenable, mem_wdata[15:0]);
    end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b1 || resp_split !== 1'b1) begin errors++; $display("FAIL split_resp got=%b%b exp=11", resp_valid, resp_split); end
    ref_store(32'h102, 2'b10, 32'hAABBCCDD);
    access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, rd, sp, lat);
    checks++; if (rd !== 32'hAABBCCDD) begin errors++; $display("FAIL split_lw got=%h exp=aabbccdd", rd); end
    checks++; if (sp !== 1'b1) begin errors++; $display("FAIL split_lw_flag got=%b exp=1", sp); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL split_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic sp; int lat; bit ok;
    start_req(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h00009C34, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_accept got=timeout exp=accept"); end
    checks++; if (mem_addr !== 32'hFFFFFFFF || mem_wenable !== 4'b0001) begin errors++; $display("FAIL wrap_acc1 got=%h/%b exp=ffffffff/0001", mem_addr, mem_wenable); end
    @(posedge clk); #1;
    checks++; if (mem_addr !== 32'h0 || mem_wenable !== 4'b0001 || mem_wdata[7:0] !== 8'h9C) begin
      errors++; $display("FAIL wrap_acc2 got=%h/%b/%h exp=00000000/0001/9c", mem_addr, mem_wenable, mem_wdata[7:0]);
    end
    @(posedge clk); #1;
    ref_store(32'hFFFFFFFF, 2'b01, 32'h00009C34);
    access(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, rd, sp, lat);
    checks++; if (rd !== 32'hFFFF9C34) begin errors++; $display("FAIL wrap_lh got=%h exp=ffff9c34", rd); end
    access(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0, rd, sp, lat);
    checks++; if (rd !== 32'h00009C34) begin errors++; $display("FAIL wrap_lhu got=%h exp=00009c34", rd); end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] rd; logic sp; int lat; bit ok;
    logic [31:0] exp_hi, got_hi;
    exp_hi = {ref_mem[10'h1F7], ref_mem[10'h1F6], ref_mem[10'h1F5], ref_mem[10'h1F4]};
    start_req(1'b1, 2'b10, 1'b0, 32'h1F2, 32'h55667788, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_accept got=timeout exp=accept"); end
    @(posedge clk); #1;
    checks++; if (mem_addr !== 32'h1F4 || mem_wenable !== 4'b0011) begin errors++; $display("FAIL rstmid_acc2 got=%h/%b exp=000001f4/0011", mem_addr, mem_wenable); end
    rst = 1'b1;
    #1;
    checks++; if (mem_wenable !== 4'b0000) begin errors++; $display("FAIL rstmid_wen got=%b exp=0000", mem_wenable); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got=%b%b exp=10", req_ready, resp_valid); end
    checks++; if (resp_rdata !== 32'h0 || resp_split !== 1'b0) begin errors++; $display("FAIL rstmid_clear got=%h/%b exp=0/0", resp_rdata, resp_split); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_noresp got=%b exp=0", resp_valid); end
    end
    // Only the first-word half of the store reached memory.
    ref_store(32'h1F2, 2'b01, 32'h00007788);
    got_hi = {mem[10'h1F7], mem[10'h1F6], mem[10'h1F5], mem[10'h1F4]};
    checks++; if (got_hi !== exp_hi) begin errors++; $display("FAIL rstmid_word2 got=%h exp=%h", got_hi, exp_hi); end
    access(1'b0, 2'b10, 1'b0, 32'h1F0, 32'h0, rd, sp, lat);
    checks++; if (rd !== ref_load(32'h1F0, 2'b10, 1'b0)) begin errors++; $display("FAIL rstmid_word1 got=%h exp=%h", rd, ref_load(32'h1F0, 2'b10, 1'b0)); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] b_addr [8];
    logic        b_wr   [8];
    logic [31:0] b_dat  [8];
    logic [31:0] b_exp  [8];
    logic        rdy;
    int na, nr, cyc;
    for (int i = 0; i < 8; i++) begin
      b_wr[i]   = (i < 4);
      b_addr[i] = (i < 4) ? 32'h120 + 32'(i) : 32'h120 + 32'(7 - i);
      b_dat[i]  = {24'h0, 8'($urandom)};
      if (b_wr[i]) begin
        ref_store(b_addr[i], 2'b00, b_dat[i]);
        b_exp[i] = 32'h0;
      end else begin
        b_exp[i] = ref_load(b_addr[i], 2'b00, 1'b1);
      end
    end
    na = 0; nr = 0; cyc = 0;
    req_write = b_wr[0]; req_size = 2'b00; req_unsigned = 1'b1; req_addr = b_addr[0]; req_wdata = b_dat[0];
    req_valid = 1'b1;
    while ((na < 8 || nr < 8) && cyc < 80) begin
      rdy = req_ready;
      @(posedge clk); #1; cyc++;
      if (rdy && req_valid) begin
        checks++; if (nr !== na) begin errors++; $display("FAIL b2b_overlap got=%0d exp=%0d", nr, na); end
        na++;
        if (na < 8) begin
          req_write = b_wr[na]; req_addr = b_addr[na]; req_wdata = b_dat[na];
        end else begin
          req_valid = 1'b0;
        end
      end
      if (resp_valid === 1'b1 && nr < 8) begin
        checks++; if (resp_rdata !== b_exp[nr]) begin errors++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", nr, resp_rdata, b_exp[nr]); end
        nr++;
      end
    end
    req_valid = 1'b0;
    checks++; if (na !== 8 || nr !== 8) begin errors++; $display("FAIL b2b_count got=%0d/%0d exp=8/8", na, nr); end
  endtask

  task automatic test_random;
    logic [31:0] rd; logic sp; int lat;
    logic        w, u;
    logic [1:0]  sz;
    logic [31:0] a, d, e;
    int bad;
    for (int it = 0; it < 40; it++) begin
      w  = 1'($urandom);
      u  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      a  = 32'h200 + 32'($urandom_range(0, 247));
      d  = $urandom;
      e  = w ? 32'h0 : ref_load(a, sz, u);
      access(w, sz, u, a, d, rd, sp, lat);
      if (w) ref_store(a, sz, d);
      checks++; if (rd !== e) begin errors++; $display("FAIL rand_rdata[%0d] a=%h sz=%0d got=%h exp=%h", it, a, sz, rd, e); end
      checks++; if (sp !== ref_split(a, sz)) begin errors++; $display("FAIL rand_split[%0d] got=%b exp=%b", it, sp, ref_split(a, sz)); end
      checks++; if (lat !== (ref_split(a, sz) ? 3 : 2)) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", it, lat, ref_split(a, sz) ? 3 : 2); end
    end
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i]) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mem_contents got=%0d differing bytes exp=0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_word();
    test_byte_ext();
    test_split();
    test_wrap();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
